// File: rtl/modulo_sequencer.sv
// Modulo-N count sequencer: takes a modulus and repetition count over a
// valid/ready handshake, steps 0..N-1 under enable, and reports completion.
module modulo_sequencer #(
   parameter int WIDTH  = 3,
   parameter int REPS_W = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [WIDTH:0]    cfg_mod,
   input  logic [REPS_W-1:0] cfg_reps,
   input  logic              enable,
   input  logic              abort,
   output logic [WIDTH-1:0]  count,
   output logic              wrap,
   output logic              Y,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        dbg_state
);

   // Handshake: a configuration transfers on a rising edge where
   // cfg_valid and cfg_ready are both high; cfg_ready is high only in IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH:0] MOD_MIN = (WIDTH+1)'(2);
   localparam logic [WIDTH:0] MOD_MAX = {1'b1, {WIDTH{1'b0}}};

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WIDTH-1:0]    r_count;
   logic [WIDTH:0]      r_mod;
   logic [REPS_W-1:0]   r_reps;
   logic                r_y;
   logic                r_wrap;
   logic                r_err;

   logic                w_cfg_legal;
   logic                w_at_top;

   assign w_cfg_legal = (cfg_mod >= MOD_MIN) && (cfg_mod <= MOD_MAX) &&
                        (cfg_reps != '0);
   // Compare in WIDTH+1 bits so a modulus of 2^WIDTH tops out at all-ones.
   assign w_at_top    = ({1'b0, r_count} == (r_mod - (WIDTH+1)'(1)));

   // State and datapath registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_mod   <= '0;
         r_reps  <= '0;
         r_y     <= 1'b0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cfg_valid) begin
                  if (w_cfg_legal) begin
                     r_mod   <= cfg_mod;
                     r_reps  <= cfg_reps;
                     r_count <= '0;
                     r_y     <= 1'b0;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               // abort wins over a coincident wrap: no toggle, no decrement
               if (abort) begin
                  r_count <= '0;
               end else if (enable) begin
                  if (w_at_top) begin
                     r_count <= '0;
                     r_wrap  <= 1'b1;
                     r_y     <= ~r_y;
                     r_reps  <= r_reps - REPS_W'(1);
                  end else begin
                     r_count <= r_count + WIDTH'(1);
                  end
               end
            end
            default: begin
               r_count <= '0;
            end
         endcase
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (cfg_valid && w_cfg_legal) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (abort)
               w_state_nxt = ST_IDLE;
            else if (enable && w_at_top && (r_reps == REPS_W'(1)))
               w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs: registers or pure state decode
   always_comb begin
      cfg_ready = (r_state == ST_IDLE);
      busy      = (r_state == ST_RUN);
      done      = (r_state == ST_DONE);
      count     = r_count;
      wrap      = r_wrap;
      Y         = r_y;
      err       = r_err;
      dbg_state = r_state;
   end

endmodule

// File: doc/modulo_sequencer.md
Name: modulo_sequencer

Overview:
Controller that configures, runs and retires a programmable modulo-N count sequence. It owns the sequencing around the modulo counter datapath:
- accepts a modulus and a repetition count through a valid/ready handshake;
- steps the count under an enable, emitting a wrap pulse and toggling output Y at each wrap;
- reports completion after the requested number of wraps.
It sits between a host or control FSM and the counter-driven logic downstream (e.g. LED/clock-divide stages).

Parameters:
WIDTH, 3, bit width of count and modulus (modulus legal range 2..2^WIDTH)
REPS_W, 4, bit width of repetition count (legal range 1..2^REPS_W-1)

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
cfg_valid  input  1  host presents a configuration
cfg_ready  output  1  block can accept a configuration
cfg_mod  input  WIDTH+1  modulus N; count runs 0..N-1
cfg_reps  input  REPS_W  number of full wraps before completion
enable  input  1  count-advance qualifier while running
abort  input  1  cancel an in-progress run
count  output  WIDTH  current count value
wrap  output  1  one-cycle pulse, count just wrapped N-1 -> 0
Y  output  1  toggles on every wrap
busy  output  1  high while in RUN
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse, illegal configuration rejected

Behaviour:
- Reset, sampled on a rising Clk edge: state=IDLE, count=0, Y=0, wrap=0, done=0, err=0, busy=0, cfg_ready=1. Internal modulus and rep registers clear to 0. Reset overrides all other inputs, including mid-run.
- FSM states are IDLE, RUN and DONE. All outputs are registered or a pure decode of state; there is no combinational path from inputs to outputs.
- IDLE:
  - cfg_ready=1, busy=0.
  - A handshake occurs on an edge with cfg_valid=1 and cfg_ready=1.
  - If cfg_mod<2, cfg_mod>2^WIDTH or cfg_reps=0: err=1 for the next cycle, state stays IDLE, nothing is latched.
  - Otherwise: latch mod and reps, count<=0, Y<=0, state<=RUN.
  - abort and enable are ignored in IDLE.
- RUN:
  - cfg_ready=0, busy=1. cfg_valid is ignored; there is no queueing.
  - Edge with enable=1 and count<mod-1: count<=count+1, wrap<=0.
  - Edge with enable=1 and count==mod-1:
    - count<=0, wrap<=1, Y<=~Y, reps<=reps-1;
    - if reps was 1, state<=DONE.
  - Edge with enable=0: count, Y and reps hold; wrap<=0 (pause).
  - Edge with abort=1:
    - state<=IDLE, count<=0, wrap<=0;
    - Y holds its value, done is not asserted;
    - abort takes priority over a simultaneous wrap, so no Y toggle and no rep decrement.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, cfg_ready=0, count=0.
  - Next edge goes to IDLE.
  - done is high in the same cycle as the final wrap pulse.
- wrap, done and err are single-cycle pulses and are never asserted together with err.
- Y retains its last value across DONE and IDLE until the next accepted configuration clears it.
- Latency: accepted config to first count increment is 1 edge (count=0 in first RUN cycle). Full run with continuous enable takes mod*reps edges from the accept edge to entry into DONE.
- Arithmetic: modulus comparison uses WIDTH+1 bits, so mod=2^WIDTH wraps at all-ones. count never exceeds mod-1.

Test Plan:
1. Reset, then cfg_mod=5, cfg_reps=2, enable=1 held -> count 0,1,2,3,4,0,...,4,0. wrap and Y toggle occur at edges 5 and 10 after accept; Y=1 then 0. done=1 on cycle after edge 10; cfg_ready=1 after edge 11.
2. cfg_mod=1, cfg_reps=3 -> err=1 for one cycle, state IDLE, cfg_ready stays 1. Repeat with cfg_mod=4, cfg_reps=0 -> err pulse.
3. cfg_mod=3, cfg_reps=1, enable toggled 1,0,0,1,1 -> count 1,1,1,2,0. wrap fires only on last edge; done next cycle.
4. cfg_mod=4, cfg_reps=3, abort asserted at count==3 with enable=1 -> IDLE, count=0, no wrap, Y unchanged (0), no done.
5. cfg_mod=8 (2^WIDTH), cfg_reps=1 -> count reaches 7, wraps to 0, Y=1, done. Then cfg_valid during RUN of a new run is ignored (cfg_ready=0).
6. Reset asserted mid-RUN at count=2 with Y=1 -> next edge: count=0, Y=0, busy=0, cfg_ready=1, no done pulse.
